// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, signed-bit index, FSM states.
package muldiv_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  localparam int SIGNED_BIT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mul_div_negate.sv
// Conditional two's-complement: out = neg ? -in : in.
module mul_div_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] in,
  input  logic         neg,
  output logic [W-1:0] out
);

  assign out = neg ? (~in + W'(1)) : in;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_SIGNED_EN to honour op[2] as the signed-operand select.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state, state_d;
  logic [1:0]         op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [CW-1:0]      count;

  logic               is_signed, sa, sb, is_div, div0, accept, last_step;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] fix_in, fix_out;
  logic [WIDTH-1:0]   res_val;

`ifdef MULDIV_SIGNED_EN
  assign is_signed = op[SIGNED_BIT];
`else
  logic unused_signed_bit;
  assign unused_signed_bit = op[SIGNED_BIT];
  assign is_signed = 1'b0;
`endif

  assign sa     = is_signed & a[WIDTH-1];
  assign sb     = is_signed & b[WIDTH-1];
  assign is_div = op[1];
  assign div0   = is_div && (b == '0);
  assign accept = (state == IDLE) && start && !flush;
  assign last_step = (count == CW'(WIDTH - 1));

  mul_div_negate #(.W(WIDTH)) u_abs_a (.in(a), .neg(sa), .out(abs_a));
  mul_div_negate #(.W(WIDTH)) u_abs_b (.in(b), .neg(sb), .out(abs_b));

  // acc holds {product_hi, multiplier_shifting} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb_q : '0)};
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    if (op_q[1]) begin
      if (div_trial[WIDTH]) acc_step = {acc[2*WIDTH-2:0], 1'b0};
      else                  acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Full-width fix-up so signed MULH sees the negated 2*WIDTH product.
  always_comb begin
    case (op_q)
      OP_DIV:  fix_in = {{WIDTH{1'b0}}, acc_step[WIDTH-1:0]};
      OP_REM:  fix_in = {{WIDTH{1'b0}}, acc_step[2*WIDTH-1:WIDTH]};
      default: fix_in = acc_step;
    endcase
  end

  mul_div_negate #(.W(2*WIDTH)) u_fix (.in(fix_in), .neg(neg_q), .out(fix_out));

  assign res_val = (op_q == OP_MULH) ? fix_out[2*WIDTH-1:WIDTH] : fix_out[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = div0 ? DONE : BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      opb_q  <= '0;
      acc    <= '0;
      count  <= '0;
      result <= '0;
    end else if (accept) begin
      op_q  <= op[1:0];
      neg_q <= (op[1:0] == OP_REM) ? sa : (sa ^ sb);
      opb_q <= is_div ? abs_b : abs_a;
      acc   <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
      count <= '0;
      if (div0) result <= op[0] ? a : '1;
    end else if (state == BUSY && !flush) begin
      acc   <= acc_step;
      count <= count + CW'(1);
      if (last_step) result <= res_val;
    end
  end

endmodule
